// File: rtl/aes256_key_schedule_ctrl_if.sv
// Key-load and round-key stream bundle for aes256_key_schedule_ctrl.
// AES256_KS_CACHE_EN adds the replay request line.
`ifndef AES_256_KEY_LENGTH
`define AES_256_KEY_LENGTH 256
`endif
`ifndef AES_BLOCK_SIZE
`define AES_BLOCK_SIZE 128
`endif
`ifndef AES_1ST_WORD
`define AES_1ST_WORD 255:224
`define AES_2ND_WORD 223:192
`define AES_3RD_WORD 191:160
`define AES_4TH_WORD 159:128
`define AES_5TH_WORD 127:96
`define AES_6TH_WORD 95:64
`define AES_7TH_WORD 63:32
`define AES_8TH_WORD 31:0
`endif

interface aes256_key_schedule_ctrl_if;
  logic [`AES_256_KEY_LENGTH-1:0] key_in;
  logic                           start;
  logic                           start_ready;
  logic                           abort;
  logic                           rk_valid;
  logic                           rk_ready;
  logic [`AES_BLOCK_SIZE-1:0]     rk_data;
  logic [3:0]                     rk_idx;
  logic                           busy;
  logic                           done;
`ifdef AES256_KS_CACHE_EN
  logic                           replay;

  modport master (output key_in, start, abort, rk_ready, replay,
                  input  start_ready, rk_valid, rk_data, rk_idx, busy, done);
  modport slave  (input  key_in, start, abort, rk_ready, replay,
                  output start_ready, rk_valid, rk_data, rk_idx, busy, done);
`else
  modport master (output key_in, start, abort, rk_ready,
                  input  start_ready, rk_valid, rk_data, rk_idx, busy, done);
  modport slave  (input  key_in, start, abort, rk_ready,
                  output start_ready, rk_valid, rk_data, rk_idx, busy, done);
`endif
endinterface

// File: rtl/aes256_key_schedule_ctrl.sv
// AES-256 key schedule sequencer: streams rk0..rk14, one per handshake.
// Optional round-key cache with replay when AES256_KS_CACHE_EN is defined.
module aes256_key_schedule_ctrl #(
  parameter bit IDLE_CLEAR = 1'b1
) (
  input logic                       clk,
  input logic                       rst,
  aes256_key_schedule_ctrl_if.slave bus
);
  typedef enum logic [1:0] {IDLE, EMIT_LO, EMIT_HI, EXPAND} state_t;

  state_t         state, state_nxt;
  logic [255:0]   window;
  logic [3:0]     counter;
  logic           hs, replay_go, use_cache;
  logic [127:0]   cache_rk, new_key;
  logic [255:0]   exp_key;
  logic [3:0]     exp_round;

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // S-box as GF(2^8) inverse (x^254) followed by the affine map
  function automatic logic [7:0] sbox(input logic [7:0] v);
    logic [7:0] sq, inv;
    sq  = v;
    inv = 8'h01;
    for (int i = 1; i < 8; i++) begin
      sq  = gf_mul(sq, sq);
      inv = gf_mul(inv, sq);
    end
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
           {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  function automatic logic [127:0] expand_step(input logic [255:0] key, input logic [3:0] round_num);
    logic [31:0] t, w0, w1, w2, w3;
    if (!round_num[0])
      t = sub_word({key[`AES_8TH_WORD] << 8 | key[`AES_8TH_WORD] >> 24}) ^
          {8'h01 << (round_num[3:1] - 3'd1), 24'h000000};
    else
      t = sub_word(key[`AES_8TH_WORD]);
    w0 = key[`AES_1ST_WORD] ^ t;
    w1 = key[`AES_2ND_WORD] ^ w0;
    w2 = key[`AES_3RD_WORD] ^ w1;
    w3 = key[`AES_4TH_WORD] ^ w2;
    return {w0, w1, w2, w3};
  endfunction

  assign hs = bus.rk_valid && bus.rk_ready;

  // In EXPAND the key being accepted is folded into the window early so
  // the next round key is ready on the following cycle.
  always_comb begin
    exp_key   = window;
    exp_round = counter;
    if (state == EXPAND) begin
      exp_key   = {window[127:0], bus.rk_data};
      exp_round = counter + 4'd1;
    end
    new_key = expand_step(exp_key, exp_round);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (bus.abort) state_nxt = IDLE;
    else begin
      case (state)
        IDLE:    if (bus.start || replay_go) state_nxt = EMIT_LO;
        EMIT_LO: if (hs) state_nxt = EMIT_HI;
        EMIT_HI: if (hs) state_nxt = EXPAND;
        EXPAND:  if (hs && bus.rk_idx == 4'd14) state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_comb begin
    bus.start_ready = (state == IDLE);
    bus.busy        = (state != IDLE);
    bus.done        = (state == EXPAND) && hs && (bus.rk_idx == 4'd14) && !bus.abort;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      window       <= '0;
      counter      <= '0;
      bus.rk_valid <= 1'b0;
      bus.rk_data  <= '0;
      bus.rk_idx   <= '0;
    end else if (bus.abort) begin
      bus.rk_valid <= 1'b0;
      if (IDLE_CLEAR) window <= '0;
    end else begin
      case (state)
        IDLE: if (bus.start || replay_go) begin
          if (bus.start) window <= bus.key_in;
          counter      <= 4'd2;
          bus.rk_data  <= bus.start ? {bus.key_in[`AES_1ST_WORD], bus.key_in[`AES_2ND_WORD],
                                       bus.key_in[`AES_3RD_WORD], bus.key_in[`AES_4TH_WORD]}
                                    : cache_rk;
          bus.rk_idx   <= 4'd0;
          bus.rk_valid <= 1'b1;
        end
        EMIT_LO: if (hs) begin
          bus.rk_data <= use_cache ? cache_rk : window[127:0];
          bus.rk_idx  <= 4'd1;
        end
        EMIT_HI: if (hs) begin
          bus.rk_data <= use_cache ? cache_rk : new_key;
          bus.rk_idx  <= 4'd2;
        end
        EXPAND: if (hs) begin
          if (bus.rk_idx == 4'd14) begin
            bus.rk_valid <= 1'b0;
            if (IDLE_CLEAR) window <= '0;
          end else begin
            window      <= exp_key;
            counter     <= exp_round;
            bus.rk_data <= use_cache ? cache_rk : new_key;
            bus.rk_idx  <= exp_round;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef AES256_KS_CACHE_EN
  logic [127:0] cache [15];
  logic         cache_valid, replaying;
  logic [3:0]   cache_sel;

  always_comb begin
    cache_sel = 4'd0;
    if (state != IDLE && bus.rk_idx != 4'd14) cache_sel = bus.rk_idx + 4'd1;
  end

  assign cache_rk  = cache[cache_sel];
  assign replay_go = (state == IDLE) && bus.replay && cache_valid;
  assign use_cache = replaying;

  always_ff @(posedge clk) begin
    if (hs && !bus.abort) cache[bus.rk_idx] <= bus.rk_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cache_valid <= 1'b0;
      replaying   <= 1'b0;
    end else if (bus.abort) begin
      cache_valid <= 1'b0;
      replaying   <= 1'b0;
    end else if (bus.done) begin
      cache_valid <= 1'b1;
      replaying   <= 1'b0;
    end else if (state == IDLE && bus.start) begin
      cache_valid <= 1'b0;
      replaying   <= 1'b0;
    end else if (replay_go) begin
      replaying   <= 1'b1;
    end
  end
`else
  assign replay_go = 1'b0;
  assign use_cache = 1'b0;
  assign cache_rk  = '0;
`endif
endmodule

// File: tb/tb_aes256_key_schedule_ctrl.sv
// Scoreboard bench for aes256_key_schedule_ctrl: FIPS-197 AES-256 key, stalls,
// abort, start collisions, async reset and (with AES256_KS_CACHE_EN) replay.
module tb_aes256_key_schedule_ctrl;
  localparam logic [255:0] FIPS_KEY =
    256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
  localparam logic [0:255][7:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16};

  logic clk, rst;
  aes256_key_schedule_ctrl_if bus();

  aes256_key_schedule_ctrl dut (.clk(clk), .rst(rst), .bus(bus));

  int checks = 0;
  int failures = 0;
  int done_cnt = 0;
  int stalls = 0;
  logic [131:0] q[$];

  logic         prev_valid, prev_ready, prev_abort;
  logic [127:0] prev_data;
  logic [3:0]   prev_idx;
  logic         exp_done;
  logic [131:0] e;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] sub_w(input logic [31:0] w);
    return {SBOX[w[31:24]], SBOX[w[23:16]], SBOX[w[15:8]], SBOX[w[7:0]]};
  endfunction

  // Textbook w[0..59] expansion; expected keys go straight into the scoreboard
  task automatic push_seq(input logic [255:0] key);
    logic [31:0] w [60];
    logic [31:0] t;
    for (int i = 0; i < 8; i++) w[i] = key[255-32*i -: 32];
    for (int i = 8; i < 60; i++) begin
      t = w[i-1];
      if (i % 8 == 0)      t = sub_w({t[23:0], t[31:24]}) ^ {8'h01 << (i/8 - 1), 24'h000000};
      else if (i % 8 == 4) t = sub_w(t);
      w[i] = w[i-8] ^ t;
    end
    for (int r = 0; r < 15; r++)
      q.push_back({4'(r), w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]});
  endtask

  always @(negedge clk) begin
    if (rst) begin
      prev_valid = 1'b0;
      prev_ready = 1'b0;
      prev_abort = 1'b0;
    end else begin
      if (prev_valid && !prev_ready && !prev_abort) begin
        stalls++;
        check("hold_valid", 128'(bus.rk_valid), 128'(1'b1));
        check("hold_data", bus.rk_data, prev_data);
        check("hold_idx", 128'(bus.rk_idx), 128'(prev_idx));
      end
      exp_done = bus.rk_valid && bus.rk_ready && (bus.rk_idx == 4'd14) && !bus.abort;
      check("done_pulse", 128'(bus.done), 128'(exp_done));
      if (exp_done) done_cnt++;
      if (bus.rk_valid && bus.rk_ready && !bus.abort) begin
        check("sb_has_entry", 128'(q.size() != 0), 128'(1'b1));
        if (q.size() != 0) begin
          e = q.pop_front();
          check("sb_rk_idx", 128'(bus.rk_idx), 128'(e[131:128]));
          check("sb_rk_data", bus.rk_data, e[127:0]);
        end
      end
      prev_valid = bus.rk_valid;
      prev_ready = bus.rk_ready;
      prev_abort = bus.abort;
      prev_data  = bus.rk_data;
      prev_idx   = bus.rk_idx;
    end
  end

  task automatic pulse_start(input logic [255:0] key, input bit accept);
    @(posedge clk); #1;
    bus.key_in = key;
    bus.start  = 1'b1;
    if (accept) push_seq(key);
    @(posedge clk); #1;
    bus.start  = 1'b0;
  endtask

  task automatic wait_idle(input string tag, input int budget);
    int n;
    n = 0;
    while (bus.busy && n < budget) begin
      @(posedge clk); #1;
      n++;
    end
    check(tag, 128'(bus.busy), 128'(1'b0));
  endtask

  task automatic wait_idx(input string tag, input logic [3:0] idx, input int budget);
    int n;
    n = 0;
    while (!(bus.rk_valid && bus.rk_idx == idx) && n < budget) begin
      @(posedge clk); #1;
      n++;
    end
    check(tag, 128'(bus.rk_idx), 128'(idx));
  endtask

`ifdef AES256_KS_CACHE_EN
  task automatic pulse_replay(input string tag, input bit accept);
    @(posedge clk); #1;
    bus.replay = 1'b1;
    if (accept) push_seq(FIPS_KEY);
    @(posedge clk); #1;
    bus.replay = 1'b0;
    check(tag, 128'(bus.rk_valid), 128'(accept));
  endtask
`endif

  initial begin
    int k, d0;
    logic [127:0] rk2_seen, rk14_seen;
    rst        = 1'b1;
    bus.key_in = '0;
    bus.start  = 1'b0;
    bus.abort  = 1'b0;
    bus.rk_ready = 1'b0;
`ifdef AES256_KS_CACHE_EN
    bus.replay = 1'b0;
`endif
    rk2_seen  = '0;
    rk14_seen = '0;
    #3;
    check("rst_start_ready", 128'(bus.start_ready), 128'(1'b1));
    check("rst_rk_valid", 128'(bus.rk_valid), 128'(1'b0));
    check("rst_busy", 128'(bus.busy), 128'(1'b0));
    check("rst_done", 128'(bus.done), 128'(1'b0));
    check("rst_rk_idx", 128'(bus.rk_idx), 128'(4'd0));
    check("rst_rk_data", bus.rk_data, 128'h0);
    @(posedge clk); #1;
    rst = 1'b0;

`ifdef AES256_KS_CACHE_EN
    pulse_replay("replay_before_run", 1'b0);
`endif

    // Back-to-back run; start is re-pulsed in the done cycle
    bus.rk_ready = 1'b1;
    d0 = done_cnt;
    pulse_start(FIPS_KEY, 1'b1);
    check("rk0_latency_valid", 128'(bus.rk_valid), 128'(1'b1));
    check("rk0_latency_idx", 128'(bus.rk_idx), 128'(4'd0));
    check("rk0_data", bus.rk_data, 128'h000102030405060708090a0b0c0d0e0f);
    k = 0;
    while (k < 40) begin
      @(negedge clk);
      k++;
      if (bus.rk_valid && bus.rk_idx == 4'd2)  rk2_seen  = bus.rk_data;
      if (bus.rk_valid && bus.rk_idx == 4'd14) rk14_seen = bus.rk_data;
      if (bus.done) begin
        bus.key_in = ~FIPS_KEY;
        bus.start  = 1'b1;
        break;
      end
    end
    check("valid_cycles", 128'(k), 128'(15));
    @(posedge clk); #1;
    bus.start  = 1'b0;
    bus.key_in = FIPS_KEY;
    check("after_done_valid", 128'(bus.rk_valid), 128'(1'b0));
    check("after_done_busy", 128'(bus.busy), 128'(1'b0));
    @(posedge clk); #1;
    check("start_in_done_ignored", 128'(bus.busy), 128'(1'b0));
    check("fips_rk2", rk2_seen, 128'ha573c29fa176c498a97fce93a572c09c);
    check("fips_rk14", rk14_seen, 128'h24fc79ccbf0979e9371ac23c6d68de36);
    check("done_once_run1", 128'(done_cnt - d0), 128'(1));
    check("sb_drained_run1", 128'(q.size()), 128'(0));

`ifdef AES256_KS_CACHE_EN
    d0 = done_cnt;
    pulse_replay("replay_rk0_latency", 1'b1);
    wait_idle("replay_finish", 60);
    check("replay_done_once", 128'(done_cnt - d0), 128'(1));
    check("sb_drained_replay", 128'(q.size()), 128'(0));
`endif

    // Random backpressure; a start with a different key lands mid-run
    bus.rk_ready = 1'b0;
    d0 = done_cnt;
    pulse_start(FIPS_KEY, 1'b1);
    for (int c = 0; c < 300 && bus.busy; c++) begin
      bus.rk_ready = 1'($urandom_range(0, 1));
      bus.start    = (c == 5);
      bus.key_in   = (c == 5) ? ~FIPS_KEY : FIPS_KEY;
      @(posedge clk); #1;
    end
    bus.start    = 1'b0;
    bus.key_in   = FIPS_KEY;
    bus.rk_ready = 1'b1;
    check("random_finish", 128'(bus.busy), 128'(1'b0));
    check("random_done_once", 128'(done_cnt - d0), 128'(1));
    check("sb_drained_random", 128'(q.size()), 128'(0));
    check("random_saw_stall", 128'(stalls > 0), 128'(1'b1));

    // Abort while rk7 is stalled, together with a late ready
    d0 = done_cnt;
    pulse_start(FIPS_KEY, 1'b1);
    wait_idx("abort_reach_idx7", 4'd7, 40);
    bus.rk_ready = 1'b0;
    @(posedge clk); #1;
    check("abort_stalled_idx", 128'(bus.rk_idx), 128'(4'd7));
    bus.abort    = 1'b1;
    bus.rk_ready = 1'b1;
    @(posedge clk); #1;
    bus.abort = 1'b0;
    check("abort_rk_valid", 128'(bus.rk_valid), 128'(1'b0));
    check("abort_busy", 128'(bus.busy), 128'(1'b0));
    check("abort_start_ready", 128'(bus.start_ready), 128'(1'b1));
    check("abort_window_clear", dut.window[255:128] | dut.window[127:0], 128'h0);
    check("abort_no_done", 128'(done_cnt - d0), 128'(0));
    q.delete();

`ifdef AES256_KS_CACHE_EN
    pulse_replay("replay_after_abort", 1'b0);
`endif

    // Asynchronous reset between clock edges mid-EXPAND, then a clean run
    pulse_start(FIPS_KEY, 1'b1);
    wait_idx("rst_reach_idx9", 4'd9, 40);
    #3;
    rst = 1'b1;
    #2;
    check("async_rst_valid", 128'(bus.rk_valid), 128'(1'b0));
    check("async_rst_busy", 128'(bus.busy), 128'(1'b0));
    check("async_rst_start_ready", 128'(bus.start_ready), 128'(1'b1));
    check("async_rst_idx", 128'(bus.rk_idx), 128'(4'd0));
    check("async_rst_data", bus.rk_data, 128'h0);
    q.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    d0 = done_cnt;
    pulse_start(FIPS_KEY, 1'b1);
    wait_idle("post_rst_finish", 60);
    check("post_rst_done_once", 128'(done_cnt - d0), 128'(1));
    check("sb_drained_post_rst", 128'(q.size()), 128'(0));

    repeat (2) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
